// File: rtl/tester_pkg.sv
// Shared types and constants for the tester vector path (feeder and pin drivers).
package tester_pkg;
  localparam int PINS_DEF = 8;

  // Per-pin format encoding carried on FF
  localparam logic R0     = 1'b0;
  localparam logic DNRZ_L = 1'b1;

  typedef enum logic [1:0] {ST_IDLE, ST_PRIME, ST_RUN} feeder_state_e;
endpackage

// File: rtl/vector_feeder_if.sv
// Host/driver-side bus of the vector feeder: vector writes, playback control, pin outputs.
interface vector_feeder_if #(parameter int PINS = tester_pkg::PINS_DEF);
  logic              WR_EN;
  logic [2*PINS-1:0] WR_DATA;
  logic              WR_FULL;
  logic              START;
  logic              STOP;
  logic [7:0]        CYCLE_LENGTH;
  logic [PINS-1:0]   D;
  logic [PINS-1:0]   FF;
  logic              DRV_EN;
  logic              CYCLE_START;
  logic              BUSY;
  logic              DONE;
  logic [15:0]       VEC_COUNT;

  modport master (
    output WR_EN, WR_DATA, START, STOP, CYCLE_LENGTH,
    input  WR_FULL, D, FF, DRV_EN, CYCLE_START, BUSY, DONE, VEC_COUNT
  );
  modport slave (
    input  WR_EN, WR_DATA, START, STOP, CYCLE_LENGTH,
    output WR_FULL, D, FF, DRV_EN, CYCLE_START, BUSY, DONE, VEC_COUNT
  );
endinterface

// File: rtl/vector_fifo.sv
// Synchronous FIFO with wrap-bit pointers; push and pop may occur in the same clock.
module vector_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic         push_ok, pop_ok;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push_ok = push && !full;
  // empty is judged on the registered pointers, so a word pushed this clock is never popped this clock
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/vector_feeder.sv
// Buffers host test vectors and issues one {FF, D} per tester cycle, counting in lockstep with the drivers.
module vector_feeder
  import tester_pkg::*;
#(
  parameter int PINS  = PINS_DEF,
  parameter int DEPTH = 16
) (
  input  logic           CLK,
  input  logic           RST,
  vector_feeder_if.slave bus
);
  feeder_state_e   state_q, state_d;
  logic [PINS-1:0] d_q, d_d, ff_q, ff_d;
  logic            drv_en_q, drv_en_d;
  logic            done_q, done_d;
  logic [15:0]     vec_count_q, vec_count_d;
  logic            stop_req_q, stop_req_d;
  logic [7:0]      cnt_q, cnt_d;

  logic              pop, fifo_empty;
  logic [2*PINS-1:0] head;
  logic              boundary;

  vector_fifo #(.W(2*PINS), .DEPTH(DEPTH)) u_fifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (bus.WR_EN),
    .wdata (bus.WR_DATA),
    .pop   (pop),
    .rdata (head),
    .full  (bus.WR_FULL),
    .empty (fifo_empty)
  );

  assign boundary = (cnt_q == bus.CYCLE_LENGTH);

  always_comb begin
    state_d     = state_q;
    d_d         = d_q;
    ff_d        = ff_q;
    drv_en_d    = drv_en_q;
    done_d      = 1'b0;
    vec_count_d = vec_count_q;
    stop_req_d  = stop_req_q;
    pop         = 1'b0;
    // Same rule as the drivers' counters, so tester-cycle boundaries line up
    cnt_d       = (!drv_en_q || boundary) ? 8'd1 : cnt_q + 8'd1;
    case (state_q)
      ST_IDLE: begin
        if (bus.START && !fifo_empty && bus.CYCLE_LENGTH != 8'd0) begin
          state_d     = ST_PRIME;
          vec_count_d = 16'd0;
        end
      end
      ST_PRIME: begin
        pop         = 1'b1;
        {ff_d, d_d} = head;
        drv_en_d    = 1'b1;
        vec_count_d = 16'd1;
        state_d     = ST_RUN;
      end
      ST_RUN: begin
        if (bus.STOP) stop_req_d = 1'b1;
        if (boundary) begin
          if (!stop_req_q && !fifo_empty) begin
            pop         = 1'b1;
            {ff_d, d_d} = head;
            vec_count_d = (vec_count_q == 16'hFFFF) ? vec_count_q : vec_count_q + 16'd1;
          end else begin
            // D/FF hold the last vector; only the enable drops
            drv_en_d   = 1'b0;
            done_d     = 1'b1;
            stop_req_d = 1'b0;
            state_d    = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      d_q         <= '0;
      ff_q        <= {PINS{R0}};
      drv_en_q    <= 1'b0;
      done_q      <= 1'b0;
      vec_count_q <= 16'd0;
      stop_req_q  <= 1'b0;
      cnt_q       <= 8'd1;
    end else begin
      state_q     <= state_d;
      d_q         <= d_d;
      ff_q        <= ff_d;
      drv_en_q    <= drv_en_d;
      done_q      <= done_d;
      vec_count_q <= vec_count_d;
      stop_req_q  <= stop_req_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.D           = d_q;
  assign bus.FF          = ff_q;
  assign bus.DRV_EN      = drv_en_q;
  assign bus.CYCLE_START = drv_en_q && (cnt_q == 8'd1);
  assign bus.BUSY        = (state_q != ST_IDLE);
  assign bus.DONE        = done_q;
  assign bus.VEC_COUNT   = vec_count_q;
endmodule
